// File: rtl/route_lookup_arbiter_pkg.sv
// Shared constants for the routing-table lookup arbiter: address/direction
// widths, mesh size, port indices, FSM state type and a range-check helper.
`ifndef ROUTE_LOOKUP_ARBITER_DEFINES
`define ROUTE_LOOKUP_ARBITER_DEFINES
`define ADDR_SZ 4
`define BITS_DIR 3
`define NUM_NODES 9
`define DIR_LOCAL 4
`endif

package route_lookup_arbiter_pkg;

  localparam int ADDR_SZ   = `ADDR_SZ;
  localparam int BITS_DIR  = `BITS_DIR;
  localparam int NUM_NODES = `NUM_NODES;

  // Input port indices; Local is always the highest index.
  localparam int PORT_N     = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_W     = 3;
  localparam int PORT_LOCAL = 4;

  localparam logic [BITS_DIR-1:0] DIR_LOCAL_V   = BITS_DIR'(`DIR_LOCAL);
  localparam logic [ADDR_SZ-1:0]  NUM_NODES_A   = ADDR_SZ'(`NUM_NODES);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Destinations at or above the node count have no table entry.
  function automatic logic dest_out_of_range(input logic [ADDR_SZ-1:0] d);
    return (d >= NUM_NODES_A);
  endfunction

endpackage

// File: rtl/route_lookup_arbiter_if.sv
// Bundle of the per-port lookup handshake and the routing-table read port.
//
// Handshake: a requester raises req[i] with dest[i] stable and holds it until
// it sees ack[i] for one cycle; dir_out[i]/err[i] are valid from that cycle on
// and held until the next ack[i]. Dropping req[i] before ack withdraws the
// request. table_addr/table_data form a combinational read of the table.
interface route_lookup_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  import route_lookup_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]          req;
  logic [NUM_PORTS*ADDR_SZ-1:0]  dest;
  logic [ADDR_SZ-1:0]            table_addr;
  logic [BITS_DIR-1:0]           table_data;
  logic [NUM_PORTS-1:0]          ack;
  logic [NUM_PORTS*BITS_DIR-1:0] dir_out;
  logic [NUM_PORTS-1:0]          err;
  logic                          ready;
  state_e                        dbg_state;

  modport master (
    output req, dest, table_data,
    input  table_addr, ack, dir_out, err, ready, dbg_state
  );

  modport slave (
    input  req, dest, table_data,
    output table_addr, ack, dir_out, err, ready, dbg_state
  );

endinterface

// File: rtl/route_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first unmasked requester at or above the
// pointer (wrapping), and moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int N     = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     eligible;

  // Scan from the pointer upward; the first eligible port wins.
  always_comb begin
    eligible  = req & ~mask;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (!grant_vld && eligible[(int'(ptr_q) + k) % N]) begin
          grant_vld                        = 1'b1;
          grant_idx                        = IDX_W'((int'(ptr_q) + k) % N);
          grant_oh[(int'(ptr_q) + k) % N]  = 1'b1;
        end
      end
    end
  end

  // Pointer moves past the winner only when a grant is made.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      if (grant_idx == IDX_W'(N - 1)) ptr_d = '0;
      else                            ptr_d = grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/route_lookup_arbiter.sv
// Routing-table lookup arbiter: waits out table initialisation, then grants
// one lookup per cycle round-robin, drives the table address and registers
// the returned direction and range error per port with a one-cycle ack.
module route_lookup_arbiter
  import route_lookup_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 5,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  route_lookup_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              init_cnt_q, init_cnt_d;
  logic [ADDR_SZ-1:0]            addr_q, addr_d;
  logic [NUM_PORTS-1:0]          ack_q, ack_d;
  logic [NUM_PORTS-1:0]          err_q, err_d;
  logic [NUM_PORTS*BITS_DIR-1:0] dir_q, dir_d;

  logic                          run;
  logic [NUM_PORTS-1:0]          grant_oh;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_vld;
  logic [ADDR_SZ-1:0]            dest_sel;
  logic                          oor;

  assign run = (state_q == ST_RUN);

  // A port acked this cycle is masked so it cannot win twice in a row.
  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .en        (run),
    .req       (bus.req),
    .mask      (ack_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // FSM next state: count out the table-load window, then run forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
        else                         init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Address mux: granted port's destination, otherwise hold the last address.
  always_comb begin
    dest_sel = bus.dest[grant_idx*ADDR_SZ +: ADDR_SZ];
    oor      = dest_out_of_range(dest_sel);
    addr_d   = grant_vld ? dest_sel : addr_q;
  end

  // Result update for the granted port; out-of-range lookups ignore the table.
  always_comb begin
    ack_d = '0;
    err_d = err_q;
    dir_d = dir_q;
    if (grant_vld) begin
      ack_d                                = grant_oh;
      err_d[grant_idx]                     = oor;
      dir_d[grant_idx*BITS_DIR +: BITS_DIR] = oor ? DIR_LOCAL_V : bus.table_data;
    end
  end

  // State, counter, address and per-port result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      dir_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.table_addr = addr_d;
  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.dir_out    = dir_q;
  assign bus.ready      = run;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_route_lookup_arbiter.sv
// Bench for route_lookup_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model of the lookup rules.
module tb_route_lookup_arbiter;
  import route_lookup_arbiter_pkg::*;

  localparam int NP     = 5;
  localparam int INIT_C = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  route_lookup_arbiter_if #(.NUM_PORTS(NP)) bus ();

  route_lookup_arbiter #(.NUM_PORTS(NP), .INIT_CYCLES(INIT_C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Node-0 routing table of a 3x3 mesh, XY routing: east while the column
  // differs, then south; self is local. Unmapped addresses return junk.
  function automatic logic [BITS_DIR-1:0] table_model(input logic [ADDR_SZ-1:0] a);
    if (a >= 9)          return 3'd3;
    else if (a == 0)     return 3'd4;
    else if (a % 3 != 0) return 3'd1;
    else                 return 3'd2;
  endfunction

  always_comb bus.table_data = table_model(bus.table_addr);

  // ---------------- stimulus state ----------------
  logic [NP-1:0]      req;
  logic [ADDR_SZ-1:0] dest [NP];

  // ---------------- reference model ----------------
  int                  m_cnt;
  bit                  m_run;
  int                  m_ptr;
  logic [NP-1:0]       m_ack;
  logic [NP-1:0]       m_err;
  logic [BITS_DIR-1:0] m_dir [NP];
  logic [ADDR_SZ-1:0]  m_addr;

  // ---------------- scoreboard ----------------
  logic [NP-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.req = req;
    for (int i = 0; i < NP; i++) bus.dest[i*ADDR_SZ +: ADDR_SZ] = dest[i];
  endtask

  function automatic logic [NP*BITS_DIR-1:0] model_dir_flat();
    logic [NP*BITS_DIR-1:0] f;
    for (int i = 0; i < NP; i++) f[i*BITS_DIR +: BITS_DIR] = m_dir[i];
    return f;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_ptr = 0;
    m_ack = '0; m_err = '0; m_addr = '0;
    for (int i = 0; i < NP; i++) m_dir[i] = '0;
  endtask

  task automatic check_outputs(input string sfx);
    check({"ack", sfx},     bus.ack,     m_ack);
    check({"err", sfx},     bus.err,     m_err);
    check({"dir_out", sfx}, bus.dir_out, model_dir_flat());
    check({"ready", sfx},   bus.ready,   m_run);
  endtask

  // One clock cycle: apply inputs, predict the grant, check address mid-cycle,
  // advance the model on the edge and check registered outputs just after.
  task automatic step();
    int g;
    drive();
    @(negedge clk);
    g = -1;
    if (m_run)
      for (int k = 0; k < NP; k++)
        if (g < 0 && req[(m_ptr + k) % NP] && !m_ack[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
    check("table_addr", bus.table_addr, (g >= 0) ? dest[g] : m_addr);
    @(posedge clk);
    m_ack = '0;
    if (g >= 0) begin
      m_ack[g] = 1'b1;
      m_err[g] = (dest[g] >= 9);
      m_dir[g] = m_err[g] ? 3'd4 : table_model(dest[g]);
      m_ptr    = (g + 1) % NP;
      m_addr   = dest[g];
    end
    if (!m_run) begin
      if (m_cnt == INIT_C - 1) m_run = 1;
      else                     m_cnt++;
    end
    #1;
    check_outputs("");
    if (exp_q.size() > 0) check("ack_order", bus.ack, exp_q.pop_front());
  endtask

  task automatic drop_acked();
    for (int i = 0; i < NP; i++) if (m_ack[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < NP; i++) dest[i] = '0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("_rst");
    check("table_addr_rst", bus.table_addr, 0);
    reset = 1'b0;
  endtask

  task automatic wait_init();
    repeat (INIT_C) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Lookup requested during INIT is held off until ready rises.
    do_reset();
    req[0] = 1'b1; dest[0] = 4'd3;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00001);
    step(); step(); step();
    check("first_dir0", bus.dir_out[2:0], 3'd2);
    drop_acked();
    step();

    // All ports at once from a fresh pointer.
    do_reset();
    wait_init();
    req = '1;
    dest[0] = 4'd0; dest[1] = 4'd1; dest[2] = 4'd3; dest[3] = 4'd6; dest[4] = 4'd8;
    for (int i = 0; i < NP; i++) exp_q.push_back(NP'(1) << i);
    repeat (NP) begin step(); drop_acked(); end
    check("all_dirs", bus.dir_out, {3'd1, 3'd2, 3'd2, 3'd1, 3'd4});
    req = '1;
    exp_q.push_back(5'b00001);
    step(); drop_acked();
    req = '0;
    step();

    // Ports 2 and 3 both held: grants alternate.
    do_reset();
    wait_init();
    req[2] = 1'b1; req[3] = 1'b1; dest[2] = 4'd5; dest[3] = 4'd7;
    repeat (3) begin exp_q.push_back(5'b00100); exp_q.push_back(5'b01000); end
    repeat (6) step();
    req = '0;
    step();

    // Out-of-range destination, then a valid lookup clears the error.
    req[1] = 1'b1; dest[1] = 4'd12;
    step();
    check("oor_err1", bus.err[1], 1'b1);
    check("oor_dir1", bus.dir_out[5:3], 3'd4);
    drop_acked();
    step();
    req[1] = 1'b1; dest[1] = 4'd2;
    step();
    check("valid_err1", bus.err[1], 1'b0);
    check("valid_dir1", bus.dir_out[5:3], 3'd1);
    drop_acked();

    // Asynchronous reset mid-cycle with a grant pending.
    req[1] = 1'b1; dest[1] = 4'd12;
    step(); drop_acked();
    req[0] = 1'b1; dest[0] = 4'd4;
    drive();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("_async");
    @(posedge clk);
    #1;
    check_outputs("_async_edge");
    reset = 1'b0;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00001);
    step(); step(); step();
    drop_acked();
    step();

    // One-cycle pulse on Local while port 0 wins: no grant for Local,
    // pointer moves to 1 so port 1 beats Local afterwards.
    do_reset();
    wait_init();
    req[0] = 1'b1; req[4] = 1'b1; dest[0] = 4'd1; dest[4] = 4'd2;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00000);
    step();
    req[4] = 1'b0; drop_acked();
    step();
    req[1] = 1'b1; req[4] = 1'b1; dest[1] = 4'd6; dest[4] = 4'd0;
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b10000);
    step(); drop_acked();
    step(); drop_acked();
    step();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (req[i] && m_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i]  = 1'b1;
            dest[i] = ADDR_SZ'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
